// File: rtl/router_pkg.sv
// Shared router definitions: transmitter FSM encoding, packet slot layout and the
// SIZE-to-length rule used by both the transmit and receive sides.
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } tx_state_t;

    localparam int SRC_OFS      = 0;
    localparam int DST_OFS      = 1;
    localparam int SIZE_OFS     = 2;
    localparam int DATA_OFS     = 3;
    localparam int SIZE_BITS    = 3;
    localparam int LEN_OVERHEAD = 5;
    localparam int MAX_PKT_LEN  = 12;

    // Only the low SIZE bits carry the data count (n-1); the rest of the byte is ignored.
    function automatic int pkt_len(input logic [SIZE_BITS-1:0] size_field);
        return int'({29'd0, size_field}) + LEN_OVERHEAD;
    endfunction

endpackage

// File: rtl/pkt_xor_crc.sv
// Running XOR checksum over a byte stream with synchronous clear, enable and a
// compare port against the received checksum byte.
module pkt_xor_crc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] cmp_data,
    output logic             mismatch
);

    logic [WIDTH-1:0] acc;

    // Clear wins over enable so a new packet always starts from zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ data;
        end
    end

    assign mismatch = (acc != cmp_data);

endmodule

// File: rtl/packet_transmitter.sv
// Output engine of one router port: drains whole packets from the port FIFO and
// re-serialises them as a byte stream under downstream backpressure, checking the XOR CRC.
module packet_transmitter
    import router_pkg::*;
#(
    parameter int PTR_IN_SZ = 4,
    parameter int UWIDTH    = 8
) (
    input  logic                 clk2,
    input  logic                 rst,
    input  logic                 rempty_i,
    input  logic [UWIDTH-1:0]    rdata_i,
    input  logic                 stop_packet_send_i,
    output logic [PTR_IN_SZ-1:0] raddr_o,
    output logic                 rinc_o,
    output logic [UWIDTH-1:0]    pdata_o,
    output logic                 packet_valid_o,
    output logic                 crc_err_o,
    output tx_state_t            state_dbg_o
);

    // Handshake: every cycle with packet_valid_o high carries one new packet byte on
    // pdata_o. stop_packet_send_i sampled high on an edge drops packet_valid_o for the
    // following cycle and freezes the read position, so no byte is skipped or repeated.

    localparam logic [PTR_IN_SZ-1:0] SIZE_IDX = PTR_IN_SZ'(SIZE_OFS);
    localparam logic [PTR_IN_SZ-1:0] IDX_ONE  = PTR_IN_SZ'(1);

    tx_state_t            state_q, state_nxt;
    logic [PTR_IN_SZ-1:0] idx_q, idx_nxt;
    logic [PTR_IN_SZ-1:0] len_q, len_nxt;
    logic [UWIDTH-1:0]    pdata_nxt;
    logic                 valid_nxt;
    logic                 rinc_nxt;
    logic                 crc_err_nxt;
    logic                 crc_clr;
    logic                 crc_en;
    logic                 crc_mismatch;
    logic                 is_crc_byte;

    pkt_xor_crc #(
        .WIDTH(UWIDTH)
    ) u_crc (
        .clk      (clk2),
        .rst      (rst),
        .clr      (crc_clr),
        .en       (crc_en),
        .data     (rdata_i),
        .cmp_data (rdata_i),
        .mismatch (crc_mismatch)
    );

    // len_q is only valid once the SIZE byte has gone past, hence the guard.
    assign is_crc_byte = (idx_q > SIZE_IDX) && (idx_q == len_q - IDX_ONE);

    always_comb begin
        state_nxt   = state_q;
        idx_nxt     = idx_q;
        len_nxt     = len_q;
        pdata_nxt   = pdata_o;
        valid_nxt   = 1'b0;
        rinc_nxt    = 1'b0;
        crc_err_nxt = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_nxt = '0;
                if (!rempty_i && !stop_packet_send_i) begin
                    state_nxt = ST_SEND;
                    crc_clr   = 1'b1;
                end
            end

            ST_SEND: begin
                if (!stop_packet_send_i) begin
                    pdata_nxt = rdata_i;
                    valid_nxt = 1'b1;
                    if (is_crc_byte) begin
                        rinc_nxt    = 1'b1;
                        crc_err_nxt = crc_mismatch;
                        state_nxt   = ST_DONE;
                    end else begin
                        crc_en  = 1'b1;
                        idx_nxt = idx_q + IDX_ONE;
                        if (idx_q == SIZE_IDX) begin
                            len_nxt = PTR_IN_SZ'(pkt_len(rdata_i[SIZE_BITS-1:0]));
                        end
                    end
                end
            end

            ST_DONE: begin
                idx_nxt   = '0;
                state_nxt = ST_IDLE;
            end

            default: begin
                idx_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            len_q          <= '0;
            pdata_o        <= '0;
            packet_valid_o <= 1'b0;
            rinc_o         <= 1'b0;
            crc_err_o      <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            idx_q          <= idx_nxt;
            len_q          <= len_nxt;
            pdata_o        <= pdata_nxt;
            packet_valid_o <= valid_nxt;
            rinc_o         <= rinc_nxt;
            crc_err_o      <= crc_err_nxt;
        end
    end

    assign raddr_o     = idx_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_packet_transmitter.sv
// Bench for packet_transmitter: a slot-FIFO model feeds packets, and a reference model
// predicts the byte stream, pop pulses, CRC flags and their cycle positions.
module tb_packet_transmitter;
  import router_pkg::*;

  localparam int PW = 4;
  localparam int W  = 8;

  logic          clk2 = 1'b0;
  logic          rst = 1'b1;
  logic          stop_packet_send_i = 1'b0;
  logic          rempty_i;
  logic [W-1:0]  rdata_i;
  logic [PW-1:0] raddr_o;
  logic          rinc_o;
  logic [W-1:0]  pdata_o;
  logic          packet_valid_o;
  logic          crc_err_o;
  tx_state_t     state_dbg_o;

  packet_transmitter #(.PTR_IN_SZ(PW), .UWIDTH(W)) dut (
    .clk2               (clk2),
    .rst                (rst),
    .rempty_i           (rempty_i),
    .rdata_i            (rdata_i),
    .stop_packet_send_i (stop_packet_send_i),
    .raddr_o            (raddr_o),
    .rinc_o             (rinc_o),
    .pdata_o            (pdata_o),
    .packet_valid_o     (packet_valid_o),
    .crc_err_o          (crc_err_o),
    .state_dbg_o        (state_dbg_o)
  );

  // clock / cycle counter
  always #5 clk2 = ~clk2;
  int cyc = 0;
  always @(posedge clk2) cyc <= cyc + 1;

  // slot FIFO model: 16-byte slots, byte i at bits [i*8 +: 8]
  logic [127:0] pkt_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rempty_i = (wr_ptr == rd_ptr);
  assign rdata_i  = pkt_mem[rd_ptr[5:0]][{raddr_o, 3'b000} +: 8];
  always @(posedge clk2) if (rinc_o) rd_ptr <= rd_ptr + 1;

  // output monitor
  logic [W-1:0] byte_log[$];
  int           byte_cyc[$];
  int           rinc_log[$];
  int           err_log[$];
  always @(negedge clk2) begin
    if (packet_valid_o) begin
      byte_log.push_back(pdata_o);
      byte_cyc.push_back(cyc);
    end
    if (rinc_o) rinc_log.push_back(cyc);
    if (crc_err_o) err_log.push_back(cyc);
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  bit           exp_err[$];
  int           n_pass = 0;
  int           n_checks = 0;

  function automatic int pkt_len_of(input logic [127:0] s);
    return int'(s[18:16]) + 5;
  endfunction

  function automatic bit crc_bad(input logic [127:0] s);
    logic [7:0] x;
    int len;
    len = pkt_len_of(s);
    x = '0;
    for (int i = 0; i < len - 1; i++) x ^= s[i*8 +: 8];
    return x != s[(len-1)*8 +: 8];
  endfunction

  function automatic logic [127:0] make_pkt(input logic [7:0] size, input bit bad);
    logic [127:0] s;
    logic [7:0] x;
    int len;
    s = {$urandom, $urandom, $urandom, $urandom};
    s[23:16] = size;
    len = pkt_len_of(s);
    x = '0;
    for (int i = 0; i < len - 1; i++) x ^= s[i*8 +: 8];
    s[(len-1)*8 +: 8] = bad ? ~x : x;
    return s;
  endfunction

  function automatic logic [W-1:0] got_byte(input int i);
    if (i < byte_log.size()) return byte_log[i];
    return 'x;
  endfunction

  function automatic int got_cyc(input int i);
    if (i < byte_cyc.size()) return byte_cyc[i];
    return -1;
  endfunction

  function automatic int rinc_at(input int i);
    if (i < rinc_log.size()) return rinc_log[i];
    return -1;
  endfunction

  function automatic bit err_at(input int c);
    foreach (err_log[j]) if (err_log[j] == c) return 1'b1;
    return 1'b0;
  endfunction

  // driver: load a slot and record its expected stream
  task automatic push_pkt(input logic [127:0] s);
    int len;
    len = pkt_len_of(s);
    pkt_mem[wr_ptr[5:0]] = s;
    for (int i = 0; i < len; i++) exp_q.push_back(s[i*8 +: 8]);
    exp_err.push_back(crc_bad(s));
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk2); #1;
      if (rinc_log.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stop_packet_send_i = 1'b0;
    repeat (3) @(negedge clk2);
    #1;
    n_checks++; if (raddr_o !== '0) $display("FAIL reset_raddr got=%0d exp=0", raddr_o); else n_pass++;
    n_checks++; if (rinc_o !== 1'b0) $display("FAIL reset_rinc got=%b exp=0", rinc_o); else n_pass++;
    n_checks++; if (pdata_o !== '0) $display("FAIL reset_pdata got=%h exp=00", pdata_o); else n_pass++;
    n_checks++; if (packet_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", packet_valid_o); else n_pass++;
    n_checks++; if (crc_err_o !== 1'b0) $display("FAIL reset_crc_err got=%b exp=0", crc_err_o); else n_pass++;
    n_checks++; if (state_dbg_o !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", state_dbg_o, ST_IDLE); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk2);
    #1;
    n_checks++; if (packet_valid_o !== 1'b0) $display("FAIL idle_empty_valid got=%b exp=0", packet_valid_o); else n_pass++;
  endtask

  task automatic test_min_packet();
    logic [127:0] s;
    int b0, r0, e0, c;
    bit ok;
    exp_q.delete(); exp_err.delete();
    s = {$urandom, $urandom, $urandom, $urandom};
    s[39:0] = 40'hBB_AA_00_10_01;
    @(negedge clk2); #1;
    b0 = byte_log.size(); r0 = rinc_log.size(); e0 = err_log.size(); c = cyc;
    push_pkt(s);
    wait_pops(r0 + 1, 60, ok);
    repeat (3) @(negedge clk2);
    #1;
    n_checks++; if (!ok) $display("FAIL min_timeout got=no_rinc exp=rinc"); else n_pass++;
    n_checks++; if (byte_log.size() - b0 != 5) $display("FAIL min_count got=%0d exp=5", byte_log.size() - b0); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_byte(b0 + i) !== e) $display("FAIL min_byte%0d got=%h exp=%h", i, got_byte(b0 + i), e); else n_pass++;
      n_checks++; if (got_cyc(b0 + i) != c + 2 + i) $display("FAIL min_cycle%0d got=%0d exp=%0d", i, got_cyc(b0 + i), c + 2 + i); else n_pass++;
    end
    n_checks++; if (rinc_log.size() - r0 != 1) $display("FAIL min_rinc_count got=%0d exp=1", rinc_log.size() - r0); else n_pass++;
    n_checks++; if (rinc_at(r0) != c + 6) $display("FAIL min_rinc_cycle got=%0d exp=%0d", rinc_at(r0), c + 6); else n_pass++;
    n_checks++; if (err_log.size() - e0 != 0) $display("FAIL min_crc_err got=%0d exp=0", err_log.size() - e0); else n_pass++;
  endtask

  task automatic test_max_packet();
    logic [127:0] s;
    int b0, r0, e0, mx, nseen;
    bit ok;
    bit seen [0:15];
    exp_q.delete(); exp_err.delete();
    foreach (seen[k]) seen[k] = 1'b0;
    s = make_pkt(8'h0F, 1'b0);
    @(negedge clk2); #1;
    b0 = byte_log.size(); r0 = rinc_log.size(); e0 = err_log.size();
    push_pkt(s);
    mx = 0; ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk2); #1;
      seen[raddr_o] = 1'b1;
      if (int'(raddr_o) > mx) mx = int'(raddr_o);
      if (rinc_log.size() > r0) ok = 1'b1;
    end
    repeat (3) @(negedge clk2);
    #1;
    nseen = 0;
    for (int k = 0; k < 12; k++) if (seen[k]) nseen++;
    n_checks++; if (!ok) $display("FAIL max_timeout got=no_rinc exp=rinc"); else n_pass++;
    n_checks++; if (mx != 11) $display("FAIL max_raddr_peak got=%0d exp=11", mx); else n_pass++;
    n_checks++; if (nseen != 12) $display("FAIL max_raddr_sweep got=%0d exp=12", nseen); else n_pass++;
    n_checks++; if (byte_log.size() - b0 != 12) $display("FAIL max_count got=%0d exp=12", byte_log.size() - b0); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_byte(b0 + i) !== e) $display("FAIL max_byte%0d got=%h exp=%h", i, got_byte(b0 + i), e); else n_pass++;
    end
    n_checks++; if (err_log.size() - e0 != 0) $display("FAIL max_crc_err got=%0d exp=0", err_log.size() - e0); else n_pass++;
  endtask

  task automatic test_bad_crc();
    logic [127:0] s;
    int b0, r0, e0, c;
    bit ok;
    exp_q.delete(); exp_err.delete();
    s = {$urandom, $urandom, $urandom, $urandom};
    s[39:0] = 40'hBC_AA_00_10_01;
    @(negedge clk2); #1;
    b0 = byte_log.size(); r0 = rinc_log.size(); e0 = err_log.size(); c = cyc;
    push_pkt(s);
    wait_pops(r0 + 1, 60, ok);
    repeat (3) @(negedge clk2);
    #1;
    n_checks++; if (!ok) $display("FAIL bad_timeout got=no_rinc exp=rinc"); else n_pass++;
    n_checks++; if (byte_log.size() - b0 != 5) $display("FAIL bad_count got=%0d exp=5", byte_log.size() - b0); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_byte(b0 + i) !== e) $display("FAIL bad_byte%0d got=%h exp=%h", i, got_byte(b0 + i), e); else n_pass++;
    end
    n_checks++; if (rinc_at(r0) != c + 6) $display("FAIL bad_rinc_cycle got=%0d exp=%0d", rinc_at(r0), c + 6); else n_pass++;
    n_checks++; if (err_log.size() - e0 != 1) $display("FAIL bad_err_count got=%0d exp=1", err_log.size() - e0); else n_pass++;
    n_checks++; if (err_at(c + 6) !== exp_err.pop_front()) $display("FAIL bad_err_cycle got=%b exp=1", err_at(c + 6)); else n_pass++;
  endtask

  task automatic test_stall();
    logic [127:0] s;
    int b0, r0, c;
    bit ok, hit;
    exp_q.delete(); exp_err.delete();
    s = make_pkt(8'h03, 1'b0);
    @(negedge clk2); #1;
    b0 = byte_log.size(); r0 = rinc_log.size(); c = cyc;
    push_pkt(s);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk2); #1;
      if (byte_log.size() - b0 >= 4) hit = 1'b1;
    end
    stop_packet_send_i = 1'b1;
    repeat (3) @(posedge clk2);
    @(negedge clk2); #1;
    stop_packet_send_i = 1'b0;
    wait_pops(r0 + 1, 60, ok);
    repeat (3) @(negedge clk2);
    #1;
    n_checks++; if (!(hit && ok)) $display("FAIL stall_timeout got=%b%b exp=11", hit, ok); else n_pass++;
    n_checks++; if (byte_log.size() - b0 != 8) $display("FAIL stall_count got=%0d exp=8", byte_log.size() - b0); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] e;
      int ec;
      e = exp_q.pop_front();
      ec = (i <= 3) ? c + 2 + i : c + 5 + i;
      n_checks++; if (got_byte(b0 + i) !== e) $display("FAIL stall_byte%0d got=%h exp=%h", i, got_byte(b0 + i), e); else n_pass++;
      n_checks++; if (got_cyc(b0 + i) != ec) $display("FAIL stall_cycle%0d got=%0d exp=%0d", i, got_cyc(b0 + i), ec); else n_pass++;
    end
    n_checks++; if (rinc_at(r0) != c + 12) $display("FAIL stall_rinc_cycle got=%0d exp=%0d", rinc_at(r0), c + 12); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] s1, s2;
    int b0, r0, c, l1, l2, n;
    bit ok;
    exp_q.delete(); exp_err.delete();
    s1 = make_pkt(8'($urandom), $urandom_range(0, 1) == 1);
    s2 = make_pkt(8'($urandom), $urandom_range(0, 1) == 1);
    l1 = pkt_len_of(s1); l2 = pkt_len_of(s2);
    @(negedge clk2); #1;
    b0 = byte_log.size(); r0 = rinc_log.size(); c = cyc;
    push_pkt(s1);
    push_pkt(s2);
    n = exp_q.size();
    wait_pops(r0 + 2, 80, ok);
    repeat (3) @(negedge clk2);
    #1;
    n_checks++; if (!ok) $display("FAIL b2b_timeout got=%0d exp=2", rinc_log.size() - r0); else n_pass++;
    n_checks++; if (byte_log.size() - b0 != n) $display("FAIL b2b_count got=%0d exp=%0d", byte_log.size() - b0, n); else n_pass++;
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_byte(b0 + i) !== e) $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_byte(b0 + i), e); else n_pass++;
    end
    n_checks++; if (got_cyc(b0 + l1) - got_cyc(b0 + l1 - 1) != 3) $display("FAIL b2b_gap got=%0d exp=3", got_cyc(b0 + l1) - got_cyc(b0 + l1 - 1)); else n_pass++;
    n_checks++; if (got_cyc(b0 + l1) != c + l1 + 4) $display("FAIL b2b_src2_cycle got=%0d exp=%0d", got_cyc(b0 + l1), c + l1 + 4); else n_pass++;
    n_checks++; if (rinc_log.size() - r0 != 2) $display("FAIL b2b_rinc_count got=%0d exp=2", rinc_log.size() - r0); else n_pass++;
    n_checks++; if (rinc_at(r0 + 1) != c + l1 + l2 + 3) $display("FAIL b2b_rinc2_cycle got=%0d exp=%0d", rinc_at(r0 + 1), c + l1 + l2 + 3); else n_pass++;
    for (int j = 0; j < 2; j++) begin
      bit ee;
      ee = exp_err.pop_front();
      n_checks++; if (err_at(rinc_at(r0 + j)) !== ee) $display("FAIL b2b_err%0d got=%b exp=%b", j, err_at(rinc_at(r0 + j)), ee); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] s;
    int b0, b1, r0, d, len;
    bit ok, hit;
    exp_q.delete(); exp_err.delete();
    s = make_pkt(8'($urandom), $urandom_range(0, 1) == 1);
    len = pkt_len_of(s);
    @(negedge clk2); #1;
    b0 = byte_log.size(); r0 = rinc_log.size();
    push_pkt(s);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk2); #1;
      if (byte_log.size() - b0 >= 3) hit = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk2); #1;
    n_checks++; if (!hit) $display("FAIL rstmid_timeout got=%0d exp=3", byte_log.size() - b0); else n_pass++;
    n_checks++; if ({raddr_o, rinc_o, pdata_o, packet_valid_o, crc_err_o} !== '0)
      $display("FAIL rstmid_outputs got=%0d/%b/%h/%b/%b exp=0", raddr_o, rinc_o, pdata_o, packet_valid_o, crc_err_o); else n_pass++;
    @(negedge clk2); #1;
    rst = 1'b0;
    d = cyc;
    b1 = byte_log.size();
    n_checks++; if (rinc_log.size() != r0) $display("FAIL rstmid_no_rinc got=%0d exp=%0d", rinc_log.size(), r0); else n_pass++;
    n_checks++; if (b1 - b0 != 3) $display("FAIL rstmid_partial got=%0d exp=3", b1 - b0); else n_pass++;
    wait_pops(r0 + 1, 60, ok);
    repeat (3) @(negedge clk2);
    #1;
    n_checks++; if (!ok) $display("FAIL rstmid_resend_timeout got=no_rinc exp=rinc"); else n_pass++;
    n_checks++; if (byte_log.size() - b1 != len) $display("FAIL rstmid_count got=%0d exp=%0d", byte_log.size() - b1, len); else n_pass++;
    n_checks++; if (got_cyc(b1) != d + 2) $display("FAIL rstmid_restart_cycle got=%0d exp=%0d", got_cyc(b1), d + 2); else n_pass++;
    for (int i = 0; i < len; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_byte(b1 + i) !== e) $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got_byte(b1 + i), e); else n_pass++;
    end
    n_checks++; if (err_at(rinc_at(r0)) !== exp_err[0]) $display("FAIL rstmid_err got=%b exp=%b", err_at(rinc_at(r0)), exp_err[0]); else n_pass++;
  endtask

  task automatic test_random_stall();
    int b0, r0, e0, n, npk, nbad;
    bit ok;
    exp_q.delete(); exp_err.delete();
    npk = 8;
    @(negedge clk2); #1;
    b0 = byte_log.size(); r0 = rinc_log.size(); e0 = err_log.size();
    for (int j = 0; j < npk; j++) push_pkt(make_pkt(8'($urandom), $urandom_range(0, 3) == 0));
    n = exp_q.size();
    nbad = 0;
    foreach (exp_err[j]) if (exp_err[j]) nbad++;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk2); #1;
      stop_packet_send_i = ($urandom_range(0, 99) < 35);
      if (rinc_log.size() >= r0 + npk) ok = 1'b1;
    end
    stop_packet_send_i = 1'b0;
    repeat (4) @(negedge clk2);
    #1;
    n_checks++; if (!ok) $display("FAIL rand_timeout got=%0d exp=%0d", rinc_log.size() - r0, npk); else n_pass++;
    n_checks++; if (byte_log.size() - b0 != n) $display("FAIL rand_count got=%0d exp=%0d", byte_log.size() - b0, n); else n_pass++;
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_byte(b0 + i) !== e) $display("FAIL rand_byte%0d got=%h exp=%h", i, got_byte(b0 + i), e); else n_pass++;
    end
    n_checks++; if (err_log.size() - e0 != nbad) $display("FAIL rand_err_count got=%0d exp=%0d", err_log.size() - e0, nbad); else n_pass++;
    for (int j = 0; j < npk; j++) begin
      bit ee;
      ee = exp_err.pop_front();
      n_checks++; if (err_at(rinc_at(r0 + j)) !== ee) $display("FAIL rand_err%0d got=%b exp=%b", j, err_at(rinc_at(r0 + j)), ee); else n_pass++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_min_packet();
    test_max_packet();
    test_bad_crc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
